// File: rtl/sub_defs.sv
// -----------------------------------------------------------------------------
// sub_defs
// Definitions shared by the serial subtractor block.
//   ST_IDLE/ST_RUN/ST_DONE : FSM state encodings.
//   state_t                : FSM state type built from those encodings.
//   cnt_width()            : width of the bit counter for a given operand width.
// -----------------------------------------------------------------------------
package sub_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // One extra bit beyond $clog2 so the count of WIDTH RUN edges never wraps,
    // even when WIDTH is a power of two.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Lowest and highest supported operand widths.
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage : sub_defs

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor: computes a - b - c.
//   a      : minuend bit
//   b      : subtrahend bit
//   c      : incoming borrow
//   diff   : difference bit
//   borrow : outgoing borrow
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);

    // Purely combinational difference and borrow.
    always_comb begin
        diff   = a ^ b ^ c;
        borrow = (~a & c) | (~a & b) | (b & c);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: diff = a - b modulo 2^WIDTH, one bit per
// clock, least significant bit first.
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : request a new subtraction (accepted in IDLE and DONE)
//   a, b       : operands, captured only on the accepting edge
//   busy       : high for the WIDTH cycles in which bits are processed
//   done       : one-cycle pulse, result valid
//   diff       : result, held from DONE until the next accepting edge
//   borrow_out : final borrow, high iff unsigned a < unsigned b
// -----------------------------------------------------------------------------
module serial_subtractor
    import sub_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   a_sh_q,    a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
    logic [WIDTH-1:0]   diff_sh_q, diff_sh_d;
    logic               borrow_q,  borrow_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               fs_diff_s;
    logic               fs_borrow_s;

    // Per-bit arithmetic on the current LSBs and the running borrow.
    full_subtractor u_fs (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .c      (borrow_q),
        .diff   (fs_diff_s),
        .borrow (fs_borrow_s)
    );

    // Next-state logic for the FSM, datapath and registered status outputs.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    diff_sh_d = {WIDTH{1'b0}};
                    borrow_d  = 1'b0;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = RUN;
                end else begin
                    // Result registers keep their value until the next accept.
                    state_d   = IDLE;
                end
            end
            RUN: begin
                // Start is deliberately not looked at here: an operation in
                // flight can neither be restarted nor queued behind.
                diff_sh_d = {fs_diff_s, diff_sh_q[WIDTH-1:1]};
                a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
                borrow_d  = fs_borrow_s;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they register in
        // the same edge as the state itself and never overlap.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= {WIDTH{1'b0}};
            b_sh_q    <= {WIDTH{1'b0}};
            diff_sh_q <= {WIDTH{1'b0}};
            borrow_q  <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_sh_q;
    assign borrow_out = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor at WIDTH = 2, 8 and 32. Expected
// results are pushed into a per-instance queue at issue time; a monitor per
// instance pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        start_v [3];
    logic        rst_v   [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic [31:0] diff_v  [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        bo_v    [3];

    logic [32:0] exp_q [3][$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int W = (k == 0) ? 2 : ((k == 1) ? 8 : 32);

        logic [W-1:0] diff_w;
        logic         busy_w;
        logic         done_w;
        logic         bo_w;

        serial_subtractor #(.WIDTH(W)) dut (
            .clk        (clk),
            .rst        (rst_v[k]),
            .start      (start_v[k]),
            .a          (a_v[k][W-1:0]),
            .b          (b_v[k][W-1:0]),
            .busy       (busy_w),
            .done       (done_w),
            .diff       (diff_w),
            .borrow_out (bo_w)
        );

        assign diff_v[k] = 32'(diff_w);
        assign busy_v[k] = busy_w;
        assign done_v[k] = done_w;
        assign bo_v[k]   = bo_w;

        initial begin : mon
            logic [32:0] e;
            forever begin
                @(negedge clk);
                check($sformatf("w%0d_busy_and_done", W), 64'(busy_w & done_w), 64'd0);
                if (done_w) begin
                    if (exp_q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL w%0d_spurious_done: got done=1 diff=0x%0h required no pending operation",
                                 W, diff_w);
                    end else begin
                        e = exp_q[k].pop_front();
                        check($sformatf("w%0d_result", W), 64'({bo_w, diff_v[k]}), 64'(e));
                    end
                end
            end
        end
    end

    // Reference: a - b at W+1 bits; bit W is the borrow.
    task automatic push_exp(input int k, input logic [31:0] av, input logic [31:0] bv);
        int          w;
        logic [63:0] m;
        logic [63:0] r;
        w = (k == 0) ? 2 : ((k == 1) ? 8 : 32);
        m = (64'd1 << w) - 64'd1;
        r = ({32'd0, av} & m) - ({32'd0, bv} & m);
        exp_q[k].push_back({r[w], r[31:0] & m[31:0]});
    endtask

    // Present operands with start for one edge; returns at accept edge + 1.
    task automatic launch(input int k, input logic [31:0] av, input logic [31:0] bv, input bit push);
        a_v[k]     = av;
        b_v[k]     = bv;
        start_v[k] = 1'b1;
        if (push) push_exp(k, av, bv);
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
    endtask

    // Count busy cycles and the cycle (1-based) on which done appears.
    task automatic time_op(input int k, output int busy_cnt, output int done_at);
        busy_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (busy_v[k]) busy_cnt++;
            if (done_v[k]) begin
                done_at = c;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int nb;
        int nd;
        int mode;
        int pend;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            rst_v[k]   = 1'b1;
            a_v[k]     = 32'd0;
            b_v[k]     = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;

        // Reset state of every instance.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy_%0d", k), 64'(busy_v[k]), 64'd0);
            check($sformatf("rst_done_%0d", k), 64'(done_v[k]), 64'd0);
            check($sformatf("rst_diff_%0d", k), 64'(diff_v[k]), 64'd0);
            check($sformatf("rst_borrow_%0d", k), 64'(bo_v[k]), 64'd0);
        end

        // 0x5A - 0x3C: 8 busy cycles then done with 0x1E.
        launch(1, 32'h5A, 32'h3C, 1'b1);
        time_op(1, nb, nd);
        check("basic_busy_cycles", 64'(nb), 64'd8);
        check("basic_done_cycle", 64'(nd), 64'd9);
        check("basic_diff", 64'(diff_v[1]), 64'h1E);
        check("basic_borrow", 64'(bo_v[1]), 64'd0);
        repeat (3) @(negedge clk);
        check("hold_diff", 64'(diff_v[1]), 64'h1E);
        check("hold_done_low", 64'(done_v[1]), 64'd0);

        // Boundary operands.
        launch(1, 32'h00, 32'h01, 1'b1);
        time_op(1, nb, nd);
        check("zero_minus_one_diff", 64'(diff_v[1]), 64'hFF);
        check("zero_minus_one_borrow", 64'(bo_v[1]), 64'd1);
        launch(1, 32'hFF, 32'hFF, 1'b1);
        time_op(1, nb, nd);
        check("equal_diff", 64'(diff_v[1]), 64'h00);
        check("equal_borrow", 64'(bo_v[1]), 64'd0);

        // Start pulse in the 3rd RUN cycle must be ignored.
        launch(1, 32'h5A, 32'h3C, 1'b1);
        fork
            time_op(1, nb, nd);
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                a_v[1]     = 32'h10;
                b_v[1]     = 32'h01;
                start_v[1] = 1'b1;
                @(posedge clk);
                #1;
                start_v[1] = 1'b0;
            end
        join
        check("ignore_done_cycle", 64'(nd), 64'd9);
        check("ignore_diff", 64'(diff_v[1]), 64'h1E);
        repeat (12) @(negedge clk);
        check("ignore_no_restart", 64'(busy_v[1]), 64'd0);

        // Reset in the 4th RUN cycle aborts with no done pulse.
        launch(1, 32'h5A, 32'h3C, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_v[1] = 1'b1;
        @(posedge clk);
        #1;
        rst_v[1] = 1'b0;
        check("abort_busy", 64'(busy_v[1]), 64'd0);
        check("abort_done", 64'(done_v[1]), 64'd0);
        check("abort_diff", 64'(diff_v[1]), 64'd0);
        check("abort_borrow", 64'(bo_v[1]), 64'd0);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done_v[1]), 64'd0);
        end

        // First start after reset is accepted normally.
        launch(1, 32'h33, 32'h11, 1'b1);
        time_op(1, nb, nd);
        check("after_rst_done_cycle", 64'(nd), 64'd9);
        check("after_rst_diff", 64'(diff_v[1]), 64'h22);

        // Back-to-back: start held through DONE with new operands.
        launch(1, 32'h5A, 32'h3C, 1'b1);
        start_v[1] = 1'b1;
        a_v[1]     = 32'h80;
        b_v[1]     = 32'h81;
        push_exp(1, 32'h80, 32'h81);
        time_op(1, nb, nd);
        check("b2b_first_done_cycle", 64'(nd), 64'd9);
        check("b2b_first_diff", 64'(diff_v[1]), 64'h1E);
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        check("b2b_no_idle_gap", 64'(busy_v[1]), 64'd1);
        time_op(1, nb, nd);
        check("b2b_second_done_cycle", 64'(nd), 64'd9);
        check("b2b_second_diff", 64'(diff_v[1]), 64'hFF);
        check("b2b_second_borrow", 64'(bo_v[1]), 64'd1);

        // Random regression on all widths, operands scrambled while busy.
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 3; k++) begin
                mode   = $urandom_range(0, 3);
                a_v[k] = $urandom;
                b_v[k] = $urandom;
                if (mode == 0) b_v[k] = a_v[k];
                if (mode == 1) a_v[k] = 32'd0;
                push_exp(k, a_v[k], b_v[k]);
                start_v[k] = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
            pend = 1;
            for (int c = 0; c < 60 && pend != 0; c++) begin
                @(negedge clk);
                pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
                for (int k = 0; k < 3; k++) begin
                    a_v[k] = $urandom;
                    b_v[k] = $urandom;
                end
            end
            check("rand_drain", 64'(pend), 64'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("final_queues_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_subtractor
